// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// for the datapath, driving every mux select and enable, stretching memory
// states on mem_ready and pulsing retire/illegal at the end of an instruction.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RT,
  input  logic       addi,
  input  logic       andi,
  input  logic       lw,
  input  logic       sw,
  input  logic       j,
  input  logic       jal,
  input  logic       jr,
  input  logic       beq,
  input  logic       bne,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL      = 4'd12,
    JR       = 4'd13
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_RT, C_ADDI, C_ANDI, C_LW, C_SW, C_J, C_JAL, C_JR, C_BEQ, C_BNE
  } class_e;

  state_e state_q, state_d;
  class_e class_q, class_d;
  class_e dec_class;

  // Priority-encode the decoder flags so overlapping flags resolve deterministically
  always_comb begin
    dec_class = C_NONE;
    if      (RT)   dec_class = C_RT;
    else if (addi) dec_class = C_ADDI;
    else if (andi) dec_class = C_ANDI;
    else if (lw)   dec_class = C_LW;
    else if (sw)   dec_class = C_SW;
    else if (j)    dec_class = C_J;
    else if (jal)  dec_class = C_JAL;
    else if (jr)   dec_class = C_JR;
    else if (beq)  dec_class = C_BEQ;
    else if (bne)  dec_class = C_BNE;
  end

  // Next-state and class-latch logic; the class is only captured in DECODE
  always_comb begin
    state_d = FETCH;
    class_d = class_q;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        class_d = dec_class;
        case (dec_class)
          C_RT:          state_d = EXEC_R;
          C_ADDI, C_ANDI: state_d = EXEC_I;
          C_LW, C_SW:    state_d = MEM_ADDR;
          C_J:           state_d = JUMP;
          C_JAL:         state_d = JAL;
          C_JR:          state_d = JR;
          C_BEQ, C_BNE:  state_d = BRANCH;
          default:       state_d = FETCH;
        endcase
      end
      MEM_ADDR: begin
        if (class_q == C_LW)      state_d = MEM_RD;
        else if (class_q == C_SW) state_d = MEM_WR;
        else                      state_d = FETCH;
      end
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      default:  state_d = FETCH;
    endcase
  end

  // State and latched-class registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      class_q <= C_NONE;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Output decode; gated by rst_n so every output drops the moment reset asserts
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b = 2'd3;
          illegal   = (dec_class == C_NONE);
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          retire     = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = mem_ready;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
          retire    = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = (class_q == C_ANDI) ? 2'd3 : 2'd0;
        end
        WB_I: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd1;
          pc_src    = 2'd1;
          retire    = 1'b1;
          pc_write  = ((class_q == C_BEQ) & zero) | ((class_q == C_BNE) & ~zero);
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          retire   = 1'b1;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
          retire     = 1'b1;
        end
        JR: begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          retire   = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each instruction is expanded into a plan of
// phases (expected outputs, whether it waits on mem_ready) from its class,
// then driven with random flags, ready stalls and zero values.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic RT, addi, andi, lw, sw, j, jal, jr, beq, bne, zero, mem_ready;
  logic ir_write, pc_write, iord, mem_read, mem_write, reg_write, alu_src_a;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic retire, illegal;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t base;
    outs_t onReady;
    bit    stall;
    bit    isDecode;
    string name;
  } phase_t;

  // Flag vector bit order, highest priority first
  localparam int F_RT = 9, F_ADDI = 8, F_ANDI = 7, F_LW = 6, F_SW = 5;
  localparam int F_J = 4, F_JAL = 3, F_JR = 2, F_BEQ = 1, F_BNE = 0;

  phase_t plan[$];
  int testCount = 0;
  int failCount = 0;
  int instrNo = 0;

  // Free-running clock
  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .RT(RT), .addi(addi), .andi(andi), .lw(lw), .sw(sw),
    .j(j), .jal(jal), .jr(jr), .beq(beq), .bne(bne),
    .zero(zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .retire(retire), .illegal(illegal)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic outs_t sampleOuts();
    outs_t o;
    o.ir_write = ir_write;   o.pc_write = pc_write;     o.iord = iord;
    o.mem_read = mem_read;   o.mem_write = mem_write;   o.reg_write = reg_write;
    o.alu_src_a = alu_src_a; o.pc_src = pc_src;         o.reg_dst = reg_dst;
    o.mem_to_reg = mem_to_reg; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.retire = retire;       o.illegal = illegal;
    return o;
  endfunction

  function automatic logic [9:0] randomFlags();
    int r;
    logic [9:0] f;
    r = $urandom_range(0, 11);
    if (r < 10)       f = 10'(1) << r;
    else if (r == 10) f = '0;
    else              f = 10'($urandom);
    return f;
  endfunction

  function automatic int topClass(input logic [9:0] f);
    for (int i = 9; i >= 0; i--)
      if (f[i]) return i;
    return -1;
  endfunction

  task automatic addPhase(input string name, input outs_t base, input outs_t onReady,
                          input bit stall, input bit isDecode);
    phase_t p;
    p.name = name; p.base = base; p.onReady = onReady;
    p.stall = stall; p.isDecode = isDecode;
    plan.push_back(p);
  endtask

  // Expand an instruction into its expected sequence of phases
  task automatic buildPlan(input logic [9:0] f, input logic z);
    outs_t b, r;
    int cls;
    plan.delete();
    b = '0; r = '0;
    b.mem_read = 1'b1; b.alu_src_b = 2'd1;
    r.ir_write = 1'b1; r.pc_write = 1'b1;
    addPhase("FETCH", b, r, 1'b1, 1'b0);
    b = '0; r = '0;
    b.alu_src_b = 2'd3; b.illegal = (f == '0);
    addPhase("DECODE", b, r, 1'b0, 1'b1);
    cls = topClass(f);
    if (cls == F_RT) begin
      b = '0; b.alu_src_a = 1'b1; b.alu_op = 2'd2;
      addPhase("EXEC_R", b, r, 1'b0, 1'b0);
      b = '0; b.reg_write = 1'b1; b.reg_dst = 2'd1; b.retire = 1'b1;
      addPhase("WB_R", b, r, 1'b0, 1'b0);
    end else if (cls == F_ADDI || cls == F_ANDI) begin
      b = '0; b.alu_src_a = 1'b1; b.alu_src_b = 2'd2;
      b.alu_op = (cls == F_ANDI) ? 2'd3 : 2'd0;
      addPhase("EXEC_I", b, r, 1'b0, 1'b0);
      b = '0; b.reg_write = 1'b1; b.retire = 1'b1;
      addPhase("WB_I", b, r, 1'b0, 1'b0);
    end else if (cls == F_LW || cls == F_SW) begin
      b = '0; b.alu_src_a = 1'b1; b.alu_src_b = 2'd2;
      addPhase("MEM_ADDR", b, r, 1'b0, 1'b0);
      if (cls == F_LW) begin
        b = '0; b.mem_read = 1'b1; b.iord = 1'b1;
        addPhase("MEM_RD", b, r, 1'b1, 1'b0);
        b = '0; b.reg_write = 1'b1; b.mem_to_reg = 2'd1; b.retire = 1'b1;
        addPhase("MEM_WB", b, r, 1'b0, 1'b0);
      end else begin
        b = '0; b.mem_write = 1'b1; b.iord = 1'b1;
        r = '0; r.retire = 1'b1;
        addPhase("MEM_WR", b, r, 1'b1, 1'b0);
      end
    end else if (cls == F_J) begin
      b = '0; b.pc_write = 1'b1; b.pc_src = 2'd2; b.retire = 1'b1;
      addPhase("JUMP", b, r, 1'b0, 1'b0);
    end else if (cls == F_JAL) begin
      b = '0; b.pc_write = 1'b1; b.pc_src = 2'd2; b.reg_write = 1'b1;
      b.reg_dst = 2'd2; b.mem_to_reg = 2'd2; b.retire = 1'b1;
      addPhase("JAL", b, r, 1'b0, 1'b0);
    end else if (cls == F_JR) begin
      b = '0; b.pc_write = 1'b1; b.pc_src = 2'd3; b.retire = 1'b1;
      addPhase("JR", b, r, 1'b0, 1'b0);
    end else if (cls == F_BEQ || cls == F_BNE) begin
      b = '0; b.alu_src_a = 1'b1; b.alu_op = 2'd1; b.pc_src = 2'd1; b.retire = 1'b1;
      b.pc_write = (cls == F_BEQ) ? z : ~z;
      addPhase("BRANCH", b, r, 1'b0, 1'b0);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic [9:0] f, input logic z);
    @(negedge clk);
    mem_ready = ready;
    {RT, addi, andi, lw, sw, j, jal, jr, beq, bne} = f;
    zero = z;
  endtask

  // Drive and check one cycle of phase i; returns the number of end pulses seen
  task automatic runCycle(input int i, input logic ready, input logic [9:0] f,
                          input logic z, input bit advance, output int pulses);
    outs_t exp, obs;
    applyStimulus(ready, plan[i].isDecode ? f : randomFlags(), z);
    #1;
    exp = plan[i].base;
    if (plan[i].stall && ready) exp = outs_t'(exp | plan[i].onReady);
    obs = sampleOuts();
    checkOutput($sformatf("%s#%0d", plan[i].name, instrNo), 32'(obs), 32'(exp));
    pulses = int'(obs.retire) + int'(obs.illegal);
    if (advance) @(posedge clk);
  endtask

  task automatic runInstr(input logic [9:0] f, input logic z,
                          input int fetchWait, input int memWait);
    int total, p, waits;
    logic ready;
    instrNo++;
    buildPlan(f, z);
    total = 0;
    foreach (plan[i]) begin
      waits = plan[i].stall ? ((i == 0) ? fetchWait : memWait) : 0;
      for (int k = 0; k <= waits; k++) begin
        ready = plan[i].stall ? (k == waits) : 1'($urandom_range(0, 1));
        runCycle(i, ready, f, z, 1'b1, p);
        total += p;
      end
    end
    checkOutput($sformatf("pulses#%0d", instrNo), 32'(total), 32'd1);
  endtask

  // Assert reset while a store is stalled in MEM_WR, then restart
  task automatic testResetMidWrite();
    int p;
    outs_t exp;
    instrNo++;
    buildPlan(10'(1) << F_SW, 1'b0);
    for (int i = 0; i < 3; i++) runCycle(i, 1'b1, 10'(1) << F_SW, 1'b0, 1'b1, p);
    runCycle(3, 1'b0, 10'(1) << F_SW, 1'b0, 1'b0, p);
    #1 rst_n = 1'b0;
    #1 checkOutput("rstAbort", 32'(sampleOuts()), 32'd0);
    @(posedge clk);
    #1 checkOutput("rstHold", 32'(sampleOuts()), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    exp = '0; exp.mem_read = 1'b1; exp.alu_src_b = 2'd1;
    checkOutput("rstFetch", 32'(sampleOuts()), 32'(exp));
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    {RT, addi, andi, lw, sw, j, jal, jr, beq, bne} = '0;
    #12;
    checkOutput("resetOuts", 32'(sampleOuts()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runInstr(10'(1) << F_LW, 1'b0, 0, 0);
    runInstr(10'(1) << F_SW, 1'b0, 0, 3);
    runInstr(10'(1) << F_BEQ, 1'b1, 0, 0);
    runInstr(10'(1) << F_BEQ, 1'b0, 0, 0);
    runInstr(10'(1) << F_BNE, 1'b1, 0, 0);
    runInstr(10'(1) << F_BNE, 1'b0, 0, 0);
    runInstr(10'(1) << F_JAL, 1'b0, 0, 0);
    runInstr(10'd0, 1'b0, 0, 0);
    runInstr((10'(1) << F_ADDI) | (10'(1) << F_ANDI), 1'b0, 0, 0);
    runInstr(10'(1) << F_ANDI, 1'b0, 1, 0);
    runInstr(10'(1) << F_RT, 1'b0, 0, 0);
    runInstr(10'(1) << F_J, 1'b0, 2, 0);
    runInstr(10'(1) << F_JR, 1'b0, 0, 0);
    testResetMidWrite();

    for (int n = 0; n < 300; n++)
      runInstr(randomFlags(), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
